// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Single-byte full-duplex SPI master. Programmable sck
//               half-period (comp+1 clk cycles), polarity, phase, bit order
//               and independent drive/capture enables. Settings are captured
//               when a request is accepted, so a transfer in flight is
//               immune to later input changes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] comp,
    input  logic       cpol,
    input  logic       cpha,
    input  logic [1:0] tr_en,
    input  logic       msb_lsb,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    input  logic       tx_req,
    output logic       tx_req_ack,
    output logic       sck,
    output logic       cs,
    output logic       sdo,
    input  logic       sdi
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_XFER   = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;
    localparam logic [4:0] c_LAST_EDGE = 5'd16;

    logic [1:0] r_state;
    logic [1:0] w_state_next;

    // Shadow copies of the configuration, taken when a request is accepted
    logic [7:0] r_comp;
    logic       r_cpol;
    logic       r_cpha;
    logic       r_msb;
    logic [1:0] r_tr_en;

    logic [7:0] r_cnt;      // half-period counter, 0..r_comp
    logic [4:0] r_edge;     // number of sck edges already produced
    logic [7:0] r_tx;       // bits still to be presented on sdo
    logic [7:0] r_rx;       // bits captured so far
    logic [7:0] r_rx_data;
    logic       r_sck;
    logic       r_cs;
    logic       r_sdo;
    logic       r_ack;

    logic       w_wrap;
    logic       w_last;
    logic [4:0] w_edge_next;
    logic       w_odd;
    logic       w_shift;
    logic       w_sample;

    assign w_wrap      = (r_cnt == r_comp);
    assign w_last      = w_wrap && (r_edge == c_LAST_EDGE);
    assign w_edge_next = r_edge + 5'd1;
    assign w_odd       = w_edge_next[0];
    // Mode cpha=0 presents bit 0 at cs fall, so only edges 2..14 shift;
    // cpha=1 presents every bit on an odd (leading) edge.
    assign w_shift     = r_cpha ? w_odd : (!w_odd && (w_edge_next != c_LAST_EDGE));
    assign w_sample    = r_cpha ? !w_odd : w_odd;

    assign rx_data    = r_rx_data;
    assign tx_req_ack = r_ack;
    assign sck        = r_sck;
    assign cs         = r_cs;
    assign sdo        = r_sdo;

    // Next-state decode for the transfer sequencer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (tx_req) w_state_next = c_ST_XFER;
            c_ST_XFER: if (w_last) w_state_next = c_ST_DONE;
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) r_state <= c_ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Pin timing, shift registers and configuration shadows
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_comp    <= 8'd0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_msb     <= 1'b0;
            r_tr_en   <= 2'b00;
            r_cnt     <= 8'd0;
            r_edge    <= 5'd0;
            r_tx      <= 8'd0;
            r_rx      <= 8'd0;
            r_rx_data <= 8'd0;
            r_sck     <= 1'b0;
            r_cs      <= 1'b1;
            r_sdo     <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_sck <= cpol;
                    r_cs  <= 1'b1;
                    r_sdo <= 1'b0;
                    if (tx_req) begin
                        r_comp  <= comp;
                        r_cpol  <= cpol;
                        r_cpha  <= cpha;
                        r_msb   <= msb_lsb;
                        r_tr_en <= tr_en;
                        r_cnt   <= 8'd0;
                        r_edge  <= 5'd0;
                        r_rx    <= 8'd0;
                        r_cs    <= 1'b0;
                        if (!cpha) begin
                            // First bit goes out with cs; keep the rest queued
                            r_sdo <= tr_en[0] & (msb_lsb ? tx_data[7] : tx_data[0]);
                            r_tx  <= msb_lsb ? {tx_data[6:0], 1'b0} : {1'b0, tx_data[7:1]};
                        end else begin
                            r_tx  <= tx_data;
                        end
                    end
                end
                c_ST_XFER: begin
                    r_cnt <= w_wrap ? 8'd0 : r_cnt + 8'd1;
                    if (w_wrap) begin
                        if (r_edge == c_LAST_EDGE) begin
                            // Trailing half-period elapsed: close the frame
                            r_cs  <= 1'b1;
                            r_ack <= 1'b1;
                            r_sdo <= 1'b0;
                            r_sck <= r_cpol;
                            if (r_tr_en[1]) r_rx_data <= r_rx;
                        end else begin
                            r_sck  <= ~r_sck;
                            r_edge <= w_edge_next;
                            if (w_shift) begin
                                r_sdo <= r_tr_en[0] & (r_msb ? r_tx[7] : r_tx[0]);
                                r_tx  <= r_msb ? {r_tx[6:0], 1'b0} : {1'b0, r_tx[7:1]};
                            end
                            if (w_sample && r_tr_en[1]) begin
                                r_rx <= r_msb ? {r_rx[6:0], sdi} : {sdi, r_rx[7:1]};
                            end
                        end
                    end
                end
                c_ST_DONE: begin
                    r_cs  <= 1'b1;
                    r_sdo <= 1'b0;
                    r_sck <= r_cpol;
                end
                default: begin
                    r_cs  <= 1'b1;
                    r_sdo <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Directed self-checking bench for spi_master. Each scenario
//               task drives one transfer (or sequence) and compares pin
//               timing and received data against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic       clk     = 1'b0;
    logic       resetn  = 1'b0;
    logic [7:0] comp    = 8'd0;
    logic       cpol    = 1'b0;
    logic       cpha    = 1'b0;
    logic [1:0] tr_en   = 2'b11;
    logic       msb_lsb = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic [7:0] rx_data;
    logic       tx_req  = 1'b0;
    logic       tx_req_ack;
    logic       sck;
    logic       cs;
    logic       sdo;
    logic       sdi;

    logic       loopback = 1'b1;
    logic       sdi_drv  = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Per-transfer observations
    int         m_wait;
    int         m_lat;
    int         m_nedge;
    int         m_first;
    int         m_last;
    logic [7:0] m_seq;
    logic       m_sdo_hi;
    logic       m_sck_t0;
    bit         m_to;

    assign sdi = loopback ? sdo : sdi_drv;

    always #5 clk = ~clk;

    spi_master dut (
        .clk        (clk),
        .resetn     (resetn),
        .comp       (comp),
        .cpol       (cpol),
        .cpha       (cpha),
        .tr_en      (tr_en),
        .msb_lsb    (msb_lsb),
        .tx_data    (tx_data),
        .rx_data    (rx_data),
        .tx_req     (tx_req),
        .tx_req_ack (tx_req_ack),
        .sck        (sck),
        .cs         (cs),
        .sdo        (sdo),
        .sdi        (sdi)
    );

    // Run one transfer and record what the pins did. Called at a negedge.
    // m_seq collects sdo at each sampling edge, first bit ending up in bit 7.
    task automatic do_xfer(input logic [7:0] c, input logic p, input logic h,
                           input logic [1:0] te, input logic m, input logic [7:0] tx,
                           input bit hold, input bit rnd);
        int   cyc;
        logic prev;
        comp = c; cpol = p; cpha = h; tr_en = te; msb_lsb = m; tx_data = tx;
        tx_req = 1'b1;
        m_wait = 0; m_lat = -1; m_nedge = 0; m_first = -1; m_last = -1;
        m_seq = 8'd0; m_sdo_hi = 1'b0; m_to = 1'b0; m_sck_t0 = 1'bx;
        while (1) begin
            @(negedge clk);
            m_wait++;
            if (cs === 1'b0) break;
            if (m_wait > 20) begin
                m_to = 1'b1;
                break;
            end
        end
        if (m_to) return;
        if (!hold) tx_req = 1'b0;
        m_sck_t0 = sck;
        prev = sck;
        if (sdo === 1'b1) m_sdo_hi = 1'b1;
        cyc = 0;
        while (tx_req_ack !== 1'b1 && cyc < 6000) begin
            if (rnd) sdi_drv = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (sdo === 1'b1) m_sdo_hi = 1'b1;
            if (sck !== prev) begin
                m_nedge++;
                if (m_first < 0) m_first = cyc;
                m_last = cyc;
                if ((h == 1'b0 && (m_nedge % 2) == 1) || (h == 1'b1 && (m_nedge % 2) == 0))
                    m_seq = {m_seq[6:0], sdo};
                prev = sck;
            end
        end
        if (tx_req_ack === 1'b1) m_lat = cyc;
        else m_to = 1'b1;
    endtask

    task automatic test_reset();
        #1 resetn = 1'b1;
        #1;
        n_cmp++; if (cs !== 1'b1)         begin n_err++; $display("FAIL reset_cs got=%b exp=1", cs); end
        n_cmp++; if (sck !== 1'b0)        begin n_err++; $display("FAIL reset_sck got=%b exp=0", sck); end
        n_cmp++; if (sdo !== 1'b0)        begin n_err++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
        n_cmp++; if (tx_req_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b exp=0", tx_req_ack); end
        n_cmp++; if (rx_data !== 8'h00)   begin n_err++; $display("FAIL reset_rx got=%h exp=00", rx_data); end
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0();
        loopback = 1'b1;
        do_xfer(8'd0, 1'b0, 1'b0, 2'b11, 1'b1, 8'hA5, 1'b0, 1'b0);
        n_cmp++; if (m_wait !== 1)     begin n_err++; $display("FAIL m0_start got=%0d exp=1", m_wait); end
        n_cmp++; if (m_seq !== 8'hA5)  begin n_err++; $display("FAIL m0_sdo_seq got=%h exp=a5", m_seq); end
        n_cmp++; if (m_nedge !== 16)   begin n_err++; $display("FAIL m0_edges got=%0d exp=16", m_nedge); end
        n_cmp++; if (m_first !== 1)    begin n_err++; $display("FAIL m0_first_edge got=%0d exp=1", m_first); end
        n_cmp++; if (m_last !== 16)    begin n_err++; $display("FAIL m0_last_edge got=%0d exp=16", m_last); end
        n_cmp++; if (m_lat !== 17)     begin n_err++; $display("FAIL m0_ack_lat got=%0d exp=17", m_lat); end
        n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL m0_rx got=%h exp=a5", rx_data); end
        @(negedge clk);
        n_cmp++; if (tx_req_ack !== 1'b0 || cs !== 1'b1)
            begin n_err++; $display("FAIL m0_ack_pulse got ack=%b cs=%b exp ack=0 cs=1", tx_req_ack, cs); end
    endtask

    task automatic test_reset_mid();
        bit seen_ack;
        comp = 8'd8; cpol = 1'b0; cpha = 1'b0; tr_en = 2'b11; msb_lsb = 1'b1; tx_data = 8'hFF;
        tx_req = 1'b1;
        repeat (30) @(negedge clk);
        tx_req = 1'b0;
        n_cmp++; if (cs !== 1'b0) begin n_err++; $display("FAIL rmid_inflight_cs got=%b exp=0", cs); end
        #2 resetn = 1'b1;
        #1;
        n_cmp++; if (cs !== 1'b1 || sck !== 1'b0 || sdo !== 1'b0 || tx_req_ack !== 1'b0)
            begin n_err++; $display("FAIL rmid_pins got cs=%b sck=%b sdo=%b ack=%b exp 1 0 0 0", cs, sck, sdo, tx_req_ack); end
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rmid_rx got=%h exp=00", rx_data); end
        @(negedge clk);
        resetn = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_req_ack === 1'b1 || cs !== 1'b1) seen_ack = 1'b1;
        end
        n_cmp++; if (seen_ack) begin n_err++; $display("FAIL rmid_no_ack got=activity exp=idle"); end
    endtask

    task automatic test_mode3();
        loopback = 1'b1;
        do_xfer(8'd1, 1'b1, 1'b1, 2'b11, 1'b0, 8'h3C, 1'b0, 1'b0);
        n_cmp++; if (m_sck_t0 !== 1'b1) begin n_err++; $display("FAIL m3_sck_idle got=%b exp=1", m_sck_t0); end
        n_cmp++; if (m_nedge !== 16)    begin n_err++; $display("FAIL m3_edges got=%0d exp=16", m_nedge); end
        n_cmp++; if (m_first !== 2)     begin n_err++; $display("FAIL m3_first_edge got=%0d exp=2", m_first); end
        n_cmp++; if (m_last !== 32)     begin n_err++; $display("FAIL m3_last_edge got=%0d exp=32", m_last); end
        // LSB first: 0,0,1,1,1,1,0,0
        n_cmp++; if (m_seq !== 8'h3C)   begin n_err++; $display("FAIL m3_sdo_seq got=%h exp=3c", m_seq); end
        n_cmp++; if (m_lat !== 34)      begin n_err++; $display("FAIL m3_ack_lat got=%0d exp=34", m_lat); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_err++; $display("FAIL m3_rx got=%h exp=3c", rx_data); end
        n_cmp++; if (sck !== 1'b1)      begin n_err++; $display("FAIL m3_sck_end got=%b exp=1", sck); end
    endtask

    task automatic test_slow_rx_only();
        loopback = 1'b0;
        sdi_drv  = 1'b0;
        do_xfer(8'd255, 1'b0, 1'b0, 2'b10, 1'b1, 8'hFF, 1'b0, 1'b0);
        n_cmp++; if (m_sdo_hi !== 1'b0) begin n_err++; $display("FAIL slow_sdo_quiet got=%b exp=0", m_sdo_hi); end
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL slow_rx got=%h exp=00", rx_data); end
        n_cmp++; if (m_lat !== 4352)    begin n_err++; $display("FAIL slow_ack_lat got=%0d exp=4352", m_lat); end
        n_cmp++; if (m_first !== 256)   begin n_err++; $display("FAIL slow_first_edge got=%0d exp=256", m_first); end
    endtask

    task automatic test_tx_only();
        loopback = 1'b1;
        do_xfer(8'd0, 1'b0, 1'b0, 2'b11, 1'b1, 8'h5A, 1'b0, 1'b0);
        n_cmp++; if (rx_data !== 8'h5A) begin n_err++; $display("FAIL txo_prime_rx got=%h exp=5a", rx_data); end
        loopback = 1'b0;
        do_xfer(8'd0, 1'b0, 1'b0, 2'b01, 1'b1, 8'hC3, 1'b0, 1'b1);
        n_cmp++; if (m_seq !== 8'hC3)   begin n_err++; $display("FAIL txo_sdo_seq got=%h exp=c3", m_seq); end
        n_cmp++; if (rx_data !== 8'h5A) begin n_err++; $display("FAIL txo_rx_hold got=%h exp=5a", rx_data); end
        n_cmp++; if (m_lat !== 17)      begin n_err++; $display("FAIL txo_ack_lat got=%0d exp=17", m_lat); end
        loopback = 1'b1;
    endtask

    task automatic test_shadow_back_to_back();
        loopback = 1'b1;
        fork
            do_xfer(8'd1, 1'b0, 1'b0, 2'b11, 1'b1, 8'h96, 1'b1, 1'b0);
            begin
                repeat (6) @(negedge clk);
                cpol = 1'b1; cpha = 1'b1; comp = 8'd3; msb_lsb = 1'b0; tx_data = 8'h0F;
            end
        join
        n_cmp++; if (m_seq !== 8'h96)   begin n_err++; $display("FAIL shd_sdo_seq got=%h exp=96", m_seq); end
        n_cmp++; if (m_first !== 2)     begin n_err++; $display("FAIL shd_first_edge got=%0d exp=2", m_first); end
        n_cmp++; if (m_nedge !== 16)    begin n_err++; $display("FAIL shd_edges got=%0d exp=16", m_nedge); end
        n_cmp++; if (m_lat !== 34)      begin n_err++; $display("FAIL shd_ack_lat got=%0d exp=34", m_lat); end
        n_cmp++; if (rx_data !== 8'h96) begin n_err++; $display("FAIL shd_rx got=%h exp=96", rx_data); end
        // tx_req still high: second transfer picks up the new settings
        do_xfer(8'd3, 1'b1, 1'b1, 2'b11, 1'b0, 8'h0F, 1'b0, 1'b0);
        n_cmp++; if (m_wait !== 2)      begin n_err++; $display("FAIL b2b_start got=%0d exp=2", m_wait); end
        n_cmp++; if (m_sck_t0 !== 1'b1) begin n_err++; $display("FAIL b2b_sck_idle got=%b exp=1", m_sck_t0); end
        n_cmp++; if (m_first !== 4)     begin n_err++; $display("FAIL b2b_first_edge got=%0d exp=4", m_first); end
        n_cmp++; if (m_nedge !== 16)    begin n_err++; $display("FAIL b2b_edges got=%0d exp=16", m_nedge); end
        // LSB first of 0x0F: 1,1,1,1,0,0,0,0
        n_cmp++; if (m_seq !== 8'hF0)   begin n_err++; $display("FAIL b2b_sdo_seq got=%h exp=f0", m_seq); end
        n_cmp++; if (m_lat !== 68)      begin n_err++; $display("FAIL b2b_ack_lat got=%0d exp=68", m_lat); end
        n_cmp++; if (rx_data !== 8'h0F) begin n_err++; $display("FAIL b2b_rx got=%h exp=0f", rx_data); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_reset_mid();
        test_mode3();
        test_slow_rx_only();
        test_tx_only();
        test_shadow_back_to_back();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
